// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared screen geometry, colour constants and engine state encoding
// Revision: 1.0
// ============================================================================
package vga_pkg;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rect_fill_engine_if.sv
`default_nettype none
// ============================================================================
// rect_fill_engine_if : request and pixel-plot bundle of the rectangle engine
// Revision: 1.0
// ============================================================================
interface rect_fill_engine_if #(
    parameter int X_W      = vga_pkg::DEF_X_W,
    parameter int Y_W      = vga_pkg::DEF_Y_W,
    parameter int COLOUR_W = vga_pkg::DEF_COLOUR_W
) ();

    logic                start;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] fill_colour;
    logic                outline;

    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, x0, y0, w, h, fill_colour, outline,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, x0, y0, w, h, fill_colour, outline,
        output x, y, colour, plot, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// raster_counter : 2-D column/row offset counter, column fastest, with last flag
// Revision: 1.0
// ============================================================================
module raster_counter #(
    parameter int COL_W = 8,
    parameter int ROW_W = 7
) (
    input  wire logic             clock,
    input  wire logic             resetn,
    input  wire logic             load,
    input  wire logic             en,
    input  wire logic [COL_W-1:0] col_max,
    input  wire logic [ROW_W-1:0] row_max,
    output logic      [COL_W-1:0] col,
    output logic      [ROW_W-1:0] row,
    output logic                  last
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col == col_max) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign last = (col == col_max) && (row == row_max);

endmodule
`default_nettype wire

// File: rtl/rect_fill_engine.sv
`default_nettype none
// ============================================================================
// rect_fill_engine : one-pixel-per-clock rectangle fill/outline writer with
//                    screen-edge clipping for the VGA adapter plot port
// Revision: 1.0
// ============================================================================
module rect_fill_engine
    import vga_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    rect_fill_engine_if.slave bus
);

    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

    state_t state;
    state_t state_nxt;

    logic [X_W-1:0]      x0_l;
    logic [Y_W-1:0]      y0_l;
    logic [X_W-1:0]      w_l;
    logic [Y_W-1:0]      h_l;
    logic [COLOUR_W-1:0] colour_l;
    logic                outline_l;

    logic                accept;
    logic                empty_req;
    logic                cnt_en;
    logic                busy_c;
    logic                done_c;

    logic [X_W-1:0]      col;
    logic [Y_W-1:0]      row;
    logic [X_W-1:0]      col_max;
    logic [Y_W-1:0]      row_max;
    logic                last;

    logic [X_W:0]        abs_x;
    logic [Y_W:0]        abs_y;
    logic                in_screen;
    logic                on_border;

    assign accept    = (state == IDLE) && bus.start;
    assign empty_req = (bus.w == '0) || (bus.h == '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are captured only on acceptance so later input changes cannot disturb a draw.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x0_l      <= '0;
            y0_l      <= '0;
            w_l       <= '0;
            h_l       <= '0;
            colour_l  <= '0;
            outline_l <= 1'b0;
        end else if (accept) begin
            x0_l      <= bus.x0;
            y0_l      <= bus.y0;
            w_l       <= bus.w;
            h_l       <= bus.h;
            colour_l  <= bus.fill_colour;
            outline_l <= bus.outline;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = empty_req ? FIN : DRAW;
                end
            end
            DRAW: begin
                cnt_en = 1'b1;
                busy_c = 1'b1;
                if (last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign col_max = w_l - X_W'(1);
    assign row_max = h_l - Y_W'(1);

    raster_counter #(
        .COL_W (X_W),
        .ROW_W (Y_W)
    ) u_raster (
        .clock   (clock),
        .resetn  (resetn),
        .load    (accept),
        .en      (cnt_en),
        .col_max (col_max),
        .row_max (row_max),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    // One extra bit keeps x0+offset from wrapping back onto the visible screen.
    assign abs_x     = {1'b0, x0_l} + {1'b0, col};
    assign abs_y     = {1'b0, y0_l} + {1'b0, row};
    assign in_screen = (abs_x < X_LIM) && (abs_y < Y_LIM);
    assign on_border = (col == '0) || (col == col_max) || (row == '0) || (row == row_max);

    assign bus.x      = abs_x[X_W-1:0];
    assign bus.y      = abs_y[Y_W-1:0];
    assign bus.colour = colour_l;
    assign bus.plot   = busy_c && in_screen && (!outline_l || on_border);
    assign bus.busy   = busy_c;
    assign bus.done   = done_c;

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`default_nettype none
// ============================================================================
// tb_rect_fill_engine : directed jobs against a per-cycle expectation queue
// Revision: 1.0
// ============================================================================
module tb_rect_fill_engine;

    typedef struct {
        bit busy;
        bit done;
        bit plot;
        int x;
        int y;
        int colour;
    } exp_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    rect_fill_engine_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

    rect_fill_engine #(
        .X_W      (8),
        .Y_W      (7),
        .COLOUR_W (3),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t q[$];
    int   idle_colour = 0;
    int   n_plots = 0;
    int   n_done  = 0;
    int   done_cyc = 0;
    int   start_cyc = 0;
    int   log_x[$];
    int   log_y[$];

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Every cycle: pop the expectation for this cycle, or expect an idle engine.
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            idle_colour = e.colour;
        end else begin
            e = '{busy: 1'b0, done: 1'b0, plot: 1'b0, x: 0, y: 0, colour: idle_colour};
        end
        chk("plot",   int'(bus.plot),   int'(e.plot));
        chk("busy",   int'(bus.busy),   int'(e.busy));
        chk("done",   int'(bus.done),   int'(e.done));
        chk("colour", int'(bus.colour), e.colour);
        if (e.plot) begin
            chk("x", int'(bus.x), e.x);
            chk("y", int'(bus.y), e.y);
        end
        if (bus.plot) begin
            n_plots++;
            log_x.push_back(int'(bus.x));
            log_y.push_back(int'(bus.y));
        end
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Issue a start pulse; the model accepts it only if the engine is idle in that cycle.
    task automatic start_job(int x0, int y0, int w, int h, int col, int ol);
        @(posedge clock);
        #1;
        bus.x0          = 8'(x0);
        bus.y0          = 7'(y0);
        bus.w           = 8'(w);
        bus.h           = 7'(h);
        bus.fill_colour = 3'(col);
        bus.outline     = ol[0];
        bus.start       = 1'b1;
        if (q.size() == 0) begin
            start_cyc = cyc;
            q.push_back('{busy: 1'b0, done: 1'b0, plot: 1'b0, x: 0, y: 0, colour: idle_colour});
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    exp_t e;
                    bit   border;
                    border = (c == 0) || (c == w - 1) || (r == 0) || (r == h - 1);
                    e.busy   = 1'b1;
                    e.done   = 1'b0;
                    e.plot   = (x0 + c < 160) && (y0 + r < 120) && (ol == 0 || border);
                    e.x      = x0 + c;
                    e.y      = y0 + r;
                    e.colour = col;
                    q.push_back(e);
                end
            end
            q.push_back('{busy: 1'b0, done: 1'b1, plot: 1'b0, x: 0, y: 0, colour: col});
        end
        @(posedge clock);
        #1;
        bus.start       = 1'b0;
        bus.x0          = 8'hA5;
        bus.y0          = 7'h3C;
        bus.w           = 8'h07;
        bus.h           = 7'h05;
        bus.fill_colour = 3'(~col);
        bus.outline     = ~ol[0];
    endtask

    task automatic clear_stats();
        n_plots  = 0;
        n_done   = 0;
        done_cyc = 0;
        log_x.delete();
        log_y.delete();
    endtask

    task automatic wait_drain(int bound, string name);
        for (int i = 0; i < bound && q.size() > 0; i++) @(posedge clock);
        if (q.size() > 0) begin
            chk({name, "_timeout"}, q.size(), 0);
            q.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic run_job(int x0, int y0, int w, int h, int col, int ol, string name);
        clear_stats();
        start_job(x0, y0, w, h, col, ol);
        wait_drain(w * h + 20, name);
    endtask

    task automatic chk_pix(int idx, int ex, int ey, string name);
        chk({name, "_x"}, (idx < log_x.size()) ? log_x[idx] : -1, ex);
        chk({name, "_y"}, (idx < log_y.size()) ? log_y[idx] : -1, ey);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start       = 1'b0;
        bus.x0          = '0;
        bus.y0          = '0;
        bus.w           = '0;
        bus.h           = '0;
        bus.fill_colour = '0;
        bus.outline     = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_x",      int'(bus.x),      0);
        chk("reset_y",      int'(bus.y),      0);
        chk("reset_colour", int'(bus.colour), 0);
        chk("reset_plot",   int'(bus.plot),   0);
        resetn = 1'b1;
        repeat (2) @(posedge clock);

        run_job(0, 0, 160, 120, 7, 0, "clear");
        chk("clear_plots", n_plots, 19200);
        chk("clear_done",  n_done, 1);
        chk("clear_lat",   done_cyc - start_cyc, 19201);
        chk_pix(0,     0,   0,   "clear_first");
        chk_pix(19199, 159, 119, "clear_last");

        run_job(10, 5, 3, 2, 2, 0, "small");
        chk("small_plots", n_plots, 6);
        chk("small_lat",   done_cyc - start_cyc, 7);
        chk_pix(0, 10, 5, "small_p0");
        chk_pix(2, 12, 5, "small_p2");
        chk_pix(3, 10, 6, "small_p3");
        chk_pix(5, 12, 6, "small_p5");
        chk("small_busy_after", int'(bus.busy), 0);

        run_job(20, 20, 4, 3, 5, 1, "outline");
        chk("outline_plots", n_plots, 10);
        chk("outline_lat",   done_cyc - start_cyc, 13);
        chk_pix(4, 20, 21, "outline_p4");
        chk_pix(5, 23, 21, "outline_p5");

        run_job(30, 30, 0, 5, 1, 0, "empty");
        chk("empty_plots", n_plots, 0);
        chk("empty_done",  n_done, 1);
        chk("empty_lat",   done_cyc - start_cyc, 1);

        clear_stats();
        start_job(40, 40, 2, 2, 3, 0);
        start_job(0, 0, 50, 50, 6, 0);
        wait_drain(40, "ignored");
        chk("ignored_plots", n_plots, 4);
        chk("ignored_done",  n_done, 1);

        clear_stats();
        start_job(60, 60, 1, 1, 2, 0);
        start_job(61, 61, 3, 3, 4, 0);
        wait_drain(40, "finstart");
        chk("finstart_plots", n_plots, 1);
        chk("finstart_done",  n_done, 1);

        run_job(158, 119, 4, 2, 4, 0, "clip");
        chk("clip_plots", n_plots, 2);
        chk("clip_lat",   done_cyc - start_cyc, 9);
        chk_pix(0, 158, 119, "clip_p0");
        chk_pix(1, 159, 119, "clip_p1");

        run_job(250, 0, 10, 1, 1, 0, "wrap");
        chk("wrap_plots", n_plots, 0);
        chk("wrap_done",  n_done, 1);

        clear_stats();
        start_job(5, 5, 10, 10, 6, 0);
        repeat (4) @(posedge clock);
        #2;
        resetn = 1'b0;
        q.delete();
        idle_colour = 0;
        #1;
        chk("abort_plot", int'(bus.plot), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("abort_plots", n_plots, 4);
        chk("abort_dones", n_done, 0);

        run_job(5, 5, 10, 10, 6, 0, "redo");
        chk("redo_plots", n_plots, 100);
        chk("redo_done",  n_done, 1);
        chk("redo_lat",   done_cyc - start_cyc, 101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
